button_debounce: RTL
====================

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive synchronized samples needed to accept a level change; legal range 2..65535.
REQ-002 The block SHALL have parameter CNT_W, default 16: width of each per-channel counter; DEBOUNCE_CYCLES SHALL be <= 2^CNT_W - 1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 redbtn  input  1  raw red button, asynchronous, active-low (0 = pressed), may bounce.
REQ-006 bluebtn  input  1  raw blue button, asynchronous, active-low (0 = pressed), may bounce.
REQ-007 red_clean  output  1  debounced red level, active-low; drives the downstream NAND set/reset latch input directly.
REQ-008 blue_clean  output  1  debounced blue level, active-low; drives the other latch input.
REQ-009 red_press  output  1  one-cycle high pulse when red_clean goes 1->0.
REQ-010 blue_press  output  1  one-cycle high pulse when blue_clean goes 1->0.

Function
REQ-011 Each button input SHALL pass through a two-flop synchronizer; only the second flop output (s) SHALL be used by the state machine.
REQ-012 Red and blue channels SHALL be identical and fully independent; no shared counter or state.
REQ-013 Each channel SHALL implement states RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND.
REQ-014 RELEASED: s=0 -> PRESS_PEND, counter=1; s=1 -> stay, counter=0.
REQ-015 PRESS_PEND: s=0 and counter=DEBOUNCE_CYCLES-1 -> PRESSED, clean<=0, press<=1, counter=0; s=0 otherwise -> counter+1; s=1 -> RELEASED, counter=0, no output change.
REQ-016 PRESSED: s=1 -> RELEASE_PEND, counter=1; s=0 -> stay, counter=0.
REQ-017 RELEASE_PEND: s=1 and counter=DEBOUNCE_CYCLES-1 -> RELEASED, clean<=1, counter=0; s=1 otherwise -> counter+1; s=0 -> PRESSED, counter=0, no output change.
REQ-018 Releases SHALL produce no pulse; the press pulse SHALL be exactly one cycle high and SHALL be 0 in all other cycles.
REQ-019 Latency: with raw held low from rising edge 1 (first capturing edge) onward, clean SHALL go 0 and press SHALL go 1 after edge DEBOUNCE_CYCLES+2; release latency SHALL be symmetrical.
REQ-020 Any bounce shorter than DEBOUNCE_CYCLES synchronized samples SHALL leave clean and press unchanged.
REQ-021 The counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-022 Simultaneous qualifying presses on both channels SHALL pulse red_press and blue_press in the same cycle.
REQ-023 All outputs SHALL be registered; no combinational path from raw inputs to outputs.

Reset
REQ-024 While rst=1 at a rising edge: synchronizer flops <=1, state <=RELEASED, counters <=0, red_clean=blue_clean=1, red_press=blue_press=0.
REQ-025 Reset asserted mid-debounce or while PRESSED SHALL abandon the operation without emitting a pulse; after rst deasserts, a still-held button SHALL be re-debounced in full (DEBOUNCE_CYCLES+2 edges) and then pulse once.
REQ-026 Reset values (clean=1 on both) SHALL hold the downstream latch in its hold state.

Verification (DEBOUNCE_CYCLES=4)
REQ-027 Bench SHALL cover: redbtn held 0 from edge 1 -> red_clean 1->0 and red_press=1 after edge 6, red_press=0 after edge 7; blue outputs unchanged.
REQ-028 Bench SHALL cover: redbtn low for 3 cycles then high, repeated 5 times -> red_clean stays 1, red_press never 1.
REQ-029 Bench SHALL cover: red pressed and stable, then raw bounces 1,0,1,1,0 -> red_clean stays 0, no second pulse; then held 1 for 6+ cycles -> red_clean returns 1, no pulse.
REQ-030 Bench SHALL cover: redbtn and bluebtn both go 0 at the same edge -> red_press and blue_press both 1 in the same cycle, after edge 6.
REQ-031 Bench SHALL cover: redbtn held 0, rst=1 asserted after edge 4 for 2 cycles -> no pulse before reset, outputs at reset values; after release, red_press fires exactly once, 6 edges after the first non-reset edge.

Source files
------------

// File: rtl/button_debounce.sv
// Two-button debouncer feeding a NAND set/reset latch: each raw active-low button is
// synchronized, then accepted only after DEBOUNCE_CYCLES consecutive stable samples.

module debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic clean,
    output logic press
);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_PEND,
        PRESSED,
        RELEASE_PEND
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic             sync_a;
    logic             s;
    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             clean_next;
    logic             press_next;

    // Synchronizer resets to 1 so a held button looks released until re-sampled.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= 1'b1;
            s      <= 1'b1;
            state  <= RELEASED;
            cnt    <= '0;
            clean  <= 1'b1;
            press  <= 1'b0;
        end else begin
            sync_a <= raw;
            s      <= sync_a;
            state  <= state_next;
            cnt    <= cnt_next;
            clean  <= clean_next;
            press  <= press_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = '0;
        clean_next = clean;
        press_next = 1'b0;
        case (state)
            RELEASED: begin
                if (!s) begin
                    state_next = PRESS_PEND;
                    cnt_next   = ONE;
                end
            end
            PRESS_PEND: begin
                if (s) begin
                    state_next = RELEASED;
                end else if (cnt == LAST) begin
                    state_next = PRESSED;
                    clean_next = 1'b0;
                    press_next = 1'b1;
                end else begin
                    cnt_next = cnt + ONE;
                end
            end
            PRESSED: begin
                if (s) begin
                    state_next = RELEASE_PEND;
                    cnt_next   = ONE;
                end
            end
            RELEASE_PEND: begin
                if (!s) begin
                    state_next = PRESSED;
                end else if (cnt == LAST) begin
                    state_next = RELEASED;
                    clean_next = 1'b1;
                end else begin
                    cnt_next = cnt + ONE;
                end
            end
            default: begin
                state_next = RELEASED;
            end
        endcase
    end

endmodule

module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic redbtn,
    input  logic bluebtn,
    output logic red_clean,
    output logic blue_clean,
    output logic red_press,
    output logic blue_press
);

    // Channels share nothing so one button can never disturb the other.
    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_red (
        .clk  (clk),
        .rst  (rst),
        .raw  (redbtn),
        .clean(red_clean),
        .press(red_press)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_blue (
        .clk  (clk),
        .rst  (rst),
        .raw  (bluebtn),
        .clean(blue_clean),
        .press(blue_press)
    );

endmodule
